// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port between byte producers.
// Holds a grant per burst and paces writes to one byte every two cycles.
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               fifotx_full,
  output logic               fifotx_w_en,
  output logic [7:0]         fifotx_w_data,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int OW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_owner_q, last_owner_d;
  logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
  logic [7:0]       idle_cnt_q, idle_cnt_d;
  logic             w_en_q, w_en_d;
  logic [7:0]       w_data_q, w_data_d;

  logic             can_accept;
  logic             owner_valid;
  logic             owner_last;
  logic [7:0]       owner_data;
  logic             xfer;
  logic [BW-1:0]    burst_next;
  logic             burst_cap;
  logic [7:0]       idle_run;
  logic             idle_hit;
  logic             release_now;

  logic             pick_found;
  logic [OW-1:0]    pick_idx;
  logic [OW:0]      rr_sum;
  logic [OW-1:0]    rr_cand;

  // A pending write blocks acceptance, so fifotx_full always reflects it.
  assign can_accept = !fifotx_full && !w_en_q;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_q[gi] & can_accept;
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign owner_data  = req_data[{owner_q, 3'b000} +: 8];
  assign xfer        = (state_q == ST_XFER) && owner_valid && can_accept;

  assign burst_next  = burst_cnt_q + BW'(1);
  assign burst_cap   = (burst_next == BW'(MAX_BURST));

  // Run length of idle cycles including the current one, saturating at 8 bits.
  assign idle_run    = (idle_cnt_q == 8'hFF) ? 8'hFF : idle_cnt_q + 8'd1;
  assign idle_hit    = !owner_valid && (idle_run == 8'(IDLE_TIMEOUT));

  assign release_now = (xfer && (owner_last || burst_cap)) || idle_hit;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_sum     = '0;
    rr_cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_sum = {1'b0, last_owner_q} + (OW + 1)'(k);
      if (rr_sum >= (OW + 1)'(N_REQ)) begin
        rr_sum = rr_sum - (OW + 1)'(N_REQ);
      end
      rr_cand = rr_sum[OW-1:0];
      if (!pick_found && req_valid[rr_cand]) begin
        pick_found = 1'b1;
        pick_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    w_en_d       = 1'b0;
    w_data_d     = w_data_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d           = ST_XFER;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          burst_cnt_d       = '0;
          idle_cnt_d        = '0;
        end
      end

      ST_XFER: begin
        if (xfer) begin
          w_en_d      = 1'b1;
          w_data_d    = owner_data;
          burst_cnt_d = burst_next;
          idle_cnt_d  = '0;
        end else if (!owner_valid) begin
          idle_cnt_d  = idle_run;
        end else begin
          idle_cnt_d  = '0;
        end

        if (release_now) begin
          state_d      = ST_IDLE;
          grant_d      = '0;
          last_owner_d = owner_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= OW'(N_REQ - 1);
      burst_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      w_en_q       <= 1'b0;
      w_data_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      w_en_q       <= w_en_d;
      w_data_q     <= w_data_d;
    end
  end

  assign grant         = grant_q;
  assign busy          = (state_q == ST_XFER);
  assign fifotx_w_en   = w_en_q;
  assign fifotx_w_data = w_data_q;

endmodule
